// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_HALTED = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_wd_timer.sv
// Watchdog counter: cleared at issue, counts while waiting, saturates at TIMEOUT.
module wd_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data stages with data-first
// priority, a request/done handshake, halt freeze and a sticky time-out flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              halted,
    output logic              err
);

    arb_state_e        r_state, w_next;
    arb_owner_e        r_owner;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_halt_lat;
    logic              r_err;

    logic              w_expire;
    logic              w_idle_go;
    logic              w_issue_dm;
    logic              w_issue_if;
    logic              w_finish;
    logic [DATA_W-1:0] w_rdata;

    assign w_idle_go  = (r_state == ST_IDLE) && !halt && !mem_busy;
    assign w_issue_dm = w_idle_go && dm_req;
    assign w_issue_if = w_idle_go && !dm_req && if_req;
    // A completion in the expiry cycle wins over the time-out.
    assign w_finish   = (r_state == ST_WAIT) && (mem_done || w_expire);
    assign w_rdata    = mem_done ? mem_rdata : '0;

    wd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wd_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (r_state == ST_ISSUE),
        .i_en     (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (halt) begin
                    w_next = ST_HALTED;
                end else if (w_issue_dm || w_issue_if) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE:  w_next = ST_WAIT;
            ST_WAIT:   if (mem_done || w_expire) w_next = ST_RESP;
            ST_RESP:   w_next = (r_halt_lat || halt) ? ST_HALTED : ST_IDLE;
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en  = 1'b0;
        mem_wr  = 1'b0;
        if_done = 1'b0;
        dm_done = 1'b0;
        halted  = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                mem_en = 1'b1;
                mem_wr = r_wr;
            end
            ST_RESP: begin
                if_done = (r_owner == OWN_FETCH);
                dm_done = (r_owner == OWN_DATA);
            end
            ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_FETCH;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_halt_lat <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_issue_dm) begin
                r_owner <= OWN_DATA;
                r_wr    <= dm_wr;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
            end else if (w_issue_if) begin
                r_owner <= OWN_FETCH;
                r_wr    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
            end
            if (halt && (r_state inside {ST_ISSUE, ST_WAIT, ST_RESP})) begin
                r_halt_lat <= 1'b1;
            end
            if (w_finish) begin
                if (r_owner == OWN_FETCH) begin
                    r_if_rdata <= w_rdata;
                end else if (!r_wr) begin
                    r_dm_rdata <= w_rdata;
                end
            end
            if (w_finish && !mem_done) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;
    assign stall     = halted | (dm_req & ~dm_done) | (if_req & ~if_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: variable-latency memory responder plus a reference
// memory image predicting load/fetch data, completion cycles and error state.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_wr, halt, mem_busy;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          if_done, dm_done;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          stall, halted, err;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Responder-side memory and control knobs
    logic [DW-1:0] mem [64];
    int            lat;
    logic          resp_on;
    int            cnt;
    logic          pend_wr;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;
    int            en_count;
    logic          last_wr;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_dm;
    int            n_pass = 0;
    int            n_checks = 0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA5A5 ^ {i[7:0], i[7:0]};
        mem_done  = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
        en_count  = 0;
        last_wr   = 1'b0;
        last_addr = '0;
        last_wdata = '0;
        pend_wr   = 1'b0;
        pend_addr = '0;
        pend_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && resp_on) begin
                    mem_done = 1'b1;
                    if (pend_wr) mem[pend_addr[5:0]] = pend_wdata;
                    else         mem_rdata = mem[pend_addr[5:0]];
                end
            end
            if (mem_en) begin
                en_count++;
                cnt        = lat;
                pend_wr    = mem_wr;
                pend_addr  = mem_addr;
                pend_wdata = mem_wdata;
                last_wr    = mem_wr;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the selected done pulse, counting cycles from the current one.
    task automatic wait_done(input bit want_dm, input bit other_req, input int exp_k, input string tag);
        int k = 0;
        bit got = 0;
        bit stall_bad = 0;
        bit stray = 0;
        while (!got && k < 40) begin
            tick();
            k++;
            if (want_dm ? dm_done : if_done) got = 1;
            else if (stall !== 1'b1) stall_bad = 1;
            if (want_dm ? if_done : dm_done) stray = 1;
        end
        chk({tag, "_cycle"}, k, exp_k);
        chk({tag, "_stall_wait"}, stall_bad, 0);
        chk({tag, "_stall_done"}, stall, other_req);
        chk({tag, "_other_done"}, stray, 0);
    endtask

    task automatic run_txn(input bit do_dm, input bit wr, input logic [AW-1:0] da,
                           input logic [DW-1:0] wd, input int ld,
                           input bit do_if, input logic [AW-1:0] ia, input int li);
        lat      = do_dm ? ld : li;
        dm_req   = do_dm;
        dm_wr    = wr;
        dm_addr  = da;
        dm_wdata = wd;
        if_req   = do_if;
        if_addr  = ia;
        #1;
        chk("stall_c0", stall, do_dm | do_if);
        if (do_dm) begin
            wait_done(1, do_if, ld + 2, "dm");
            chk("dm_issue_wr", last_wr, wr);
            chk("dm_issue_addr", last_addr, da);
            if (wr) begin
                chk("dm_issue_wdata", last_wdata, wd);
                ref_mem[da[5:0]] = wd;
            end else begin
                exp_dm = ref_mem[da[5:0]];
            end
            chk("dm_rdata", dm_rdata, exp_dm);
            tick();
            dm_req = 1'b0;
            dm_wr  = 1'b0;
            lat    = li;
        end
        if (do_if) begin
            wait_done(0, 0, li + 2, "if");
            chk("if_issue_wr", last_wr, 0);
            chk("if_issue_addr", last_addr, ia);
            chk("if_rdata", if_rdata, ref_mem[ia[5:0]]);
            tick();
            if_req = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_outs"}, {mem_en, mem_wr, if_done, dm_done, halted, err, stall}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        int en0;
        bit bad;
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'hA5A5 ^ {i[7:0], i[7:0]};
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; halt = 1'b0;
        mem_busy = 1'b0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        lat = 1; resp_on = 1'b1; exp_dm = '0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Load at 0x0040 (aliases entry 0) returning 0xBEEF with L=2
        ref_mem[0] = 16'hBEEF;
        @(negedge clk);
        mem[0] = 16'hBEEF;
        tick();
        run_txn(1, 0, 16'h0040, 16'h0000, 2, 0, 16'h0000, 1);

        // Simultaneous store and fetch: store goes first
        run_txn(1, 1, 16'h0010, 16'h1234, 2, 1, 16'h0002, 3);
        run_txn(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 2);

        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                    16'($urandom), int'($urandom_range(1, TO + 1)),
                    kind != 0, 16'($urandom_range(0, 15)), int'($urandom_range(1, TO + 1)));
        end

        // mem_busy held three cycles blocks issue
        lat = 2; mem_busy = 1'b1; if_req = 1'b1; if_addr = 16'h0004;
        #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_en !== 1'b0 || stall !== 1'b1) bad = 1;
            tick();
        end
        chk("busy_no_en", {bad, mem_en}, 0);
        mem_busy = 1'b0;
        tick();
        chk("busy_en_after", mem_en, 1);
        wait_done(0, 0, 3, "busy_if");
        chk("busy_if_rdata", if_rdata, ref_mem[4]);
        tick();
        if_req = 1'b0;

        // mem_done exactly in the expiry cycle completes normally
        run_txn(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0005, TO + 1);
        chk("edge_no_err", err, 0);

        // Time-out: no mem_done ever
        resp_on = 1'b0; lat = 1; if_req = 1'b1; if_addr = 16'h0003;
        wait_done(0, 0, TO + 3, "timeout");
        chk("timeout_err", err, 1);
        chk("timeout_rdata", if_rdata, 0);
        tick();
        if_req = 1'b0;
        resp_on = 1'b1;
        run_txn(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0006, 2);
        chk("err_sticky", err, 1);

        // Halt raised in WAIT: access completes, then freeze
        lat = 3; if_req = 1'b1; if_addr = 16'h0007;
        tick();
        tick();
        halt = 1'b1;
        wait_done(0, 0, 3, "halt_txn");
        chk("halt_txn_rdata", if_rdata, ref_mem[7]);
        en0 = en_count;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (halted !== 1'b1 || stall !== 1'b1) bad = 1;
        end
        chk("halted_held", bad, 0);
        chk("halted_no_en", en_count, en0);
        halt = 1'b0; if_req = 1'b0; rst_n = 1'b0;
        exp_dm = '0;
        #1;
        check_reset_state("halt_reset");
        #2;
        rst_n = 1'b1;
        tick();

        // Halt in IDLE beats a pending fetch
        en0 = en_count;
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0008;
        tick();
        chk("idle_halt_halted", halted, 1);
        tick();
        tick();
        chk("idle_halt_no_en", en_count, en0);
        halt = 1'b0; if_req = 1'b0; rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Async reset in WAIT, then a stray mem_done arrives
        lat = 4; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0009;
        tick();
        tick();
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        check_reset_state("abort_reset");
        #2;
        rst_n = 1'b1;
        en0 = en_count;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dm_done !== 1'b0 || if_done !== 1'b0) bad = 1;
        end
        chk("abort_no_done", bad, 0);
        chk("abort_no_en", en_count, en0);
        chk("abort_dm_rdata", dm_rdata, 0);
        run_txn(1, 0, 16'h0009, 16'h0000, 2, 0, 16'h0000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-ported unified memory between instruction fetch and the data-memory stage of the WISC pipeline. Data requests come from the decoder's `read_mem`/`write_mem` decode. Arbitrates with fixed data-over-fetch priority and runs a request/done handshake with a variable-latency memory. Generates the pipeline stall, drains and freezes on halt, and flags memory time-outs.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 255, maximum wait cycles after `mem_en` before a time-out is declared (≥1)

- `clk` in 1, system clock; single clock domain
- `rst_n` in 1, asynchronous active-low reset
- `if_req` in 1, fetch request; held high until `if_done`
- `if_addr` in ADDR_W, fetch PC
- `if_rdata` out DATA_W, fetched instruction; valid with `if_done`
- `if_done` out 1, one-cycle completion pulse for fetch
- `dm_req` in 1, data request (`read_mem | write_mem`); held until `dm_done`
- `dm_wr` in 1, 1 = store, 0 = load
- `dm_addr` in ADDR_W, data address
- `dm_wdata` in DATA_W, store data
- `dm_rdata` out DATA_W, load data; valid with `dm_done`
- `dm_done` out 1, one-cycle completion pulse for data
- `halt` in 1, level from decoder `createdump`
- `mem_en` out 1, one-cycle issue strobe to memory
- `mem_wr` out 1, write qualifier for `mem_en`
- `mem_addr` out ADDR_W, issued address
- `mem_wdata` out DATA_W, issued write data
- `mem_busy` in 1, memory cannot accept an issue this cycle
- `mem_done` in 1, completion pulse from memory
- `mem_rdata` in DATA_W, read data; valid with `mem_done`
- `stall` out 1, freeze-pipeline request
- `halted` out 1, arbiter frozen after halt
- `err` out 1, sticky time-out flag

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HALTED. Register `owner` records which requester is being served (DATA or FETCH).
- IDLE transitions, in priority order:
  - `halt` high → HALTED. Halt beats any pending request, and the pending fetch is dropped.
  - `mem_busy` high → stay in IDLE.
  - `dm_req` → latch the data fields, `owner` = DATA, go to ISSUE.
  - `if_req` → latch the fetch fields with `mem_wr` = 0, `owner` = FETCH, go to ISSUE.
- ISSUE: `mem_en` = 1 for exactly this cycle, then go to WAIT. The timer clears to 0.
- WAIT:
  - Timer increments each cycle.
  - `mem_done` → capture `mem_rdata` into the owner's rdata register, go to RESP. Stores leave `dm_rdata` unchanged.
  - Timer reaches TIMEOUT without `mem_done` → set `err`, load 0x0000 into the owner's rdata (loads and fetches only), go to RESP.
  - `mem_done` in the expiry cycle → treated as a normal completion; `err` is not set.
- RESP: the owner's `*_done` = 1 for one cycle.
  - `halt` latched during ISSUE/WAIT/RESP → next state HALTED.
  - Otherwise → IDLE.
- HALTED: absorbing until reset. No issues are made, and `halted` = 1.
- `mem_done` outside WAIT is ignored.
- `stall` (combinational) = HALTED, or (`dm_req` & !`dm_done`), or (`if_req` & !`if_done`).
- `err` is sticky until reset and does not block further operation.

## Timing
- Reset (async): state IDLE, all outputs 0, timer 0, halt latch 0, rdata registers 0x0000.
- Let L = cycles from `mem_en` to `mem_done` (L ≥ 1). With the request sampled in IDLE at cycle 0:
  - `mem_en` at cycle 1
  - `mem_done` at cycle 1+L
  - `*_done` at cycle 2+L
- Throughput: one access per L+3 cycles. A requester drops its req the cycle after `*_done`, so the following IDLE sees fresh requests.
- Time-out: `*_done` at cycle TIMEOUT+2 after `mem_en`.
- Reset mid-transaction aborts immediately. No `*_done` is produced, and a later stray `mem_done` is ignored.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3, HALTED=4)
  - owner encoding (DATA=1, FETCH=0)
  - defaults for ADDR_W, DATA_W, TIMEOUT
- One sub-module, `wd_timer`:
  - clear/enable counter of width clog2(TIMEOUT+1)
  - `expire` output high when the count equals TIMEOUT

## Test plan
- Load, L=2: `dm_req`=1, `dm_wr`=0, `dm_addr`=0x0040, memory returns 0xBEEF → `mem_en` at cycle 1, `dm_done` with `dm_rdata`=0xBEEF at cycle 4, `stall` high in cycles 0–3.
- Simultaneous: `if_req` (0x0002) and `dm_req` store (0x0010, 0x1234) at cycle 0 → store issued first with `mem_wr`=1; fetch issued at the IDLE after `dm_done`; `if_rdata` = memory value.
- `mem_busy` held for 3 cycles with `if_req` high → no `mem_en` until `mem_busy` falls; `mem_en` asserts the cycle after.
- Time-out with TIMEOUT=4 and `mem_done` never asserted → `err`=1, `if_done` with `if_rdata`=0x0000 at cycle 6 after `mem_en`; the next fetch still completes normally.
- `halt` raised during WAIT → the current access completes with `*_done`, then HALTED; `halted`=1, `stall`=1, and no further `mem_en` despite `if_req`. `rst_n` low → everything returns to 0.
- Async reset asserted in WAIT and released, then a late `mem_done` arrives → no `*_done`, state IDLE.
